game_soc_gpio_pio: RTL and testbench

Parametrised Avalon-MM general-purpose I/O block for the game SoC. It replaces the fixed 14-bit output-only LED port with a WIDTH-bit bidirectional port that has:
- per-bit direction control;
- atomic set/clear writes;
- synchronised, edge-captured inputs;
- a level interrupt.

It sits on the system interconnect as a zero-wait-state slave. It drives LEDs, reads buttons and switches, and raises an IRQ to the CPU.

---
 rtl/game_soc_gpio_pkg.sv | 18 +
 rtl/game_soc_gpio_debounce.sv | 45 ++++
 rtl/game_soc_gpio_pio.sv | 131 +++++++++++++
 tb/tb_game_soc_gpio_pio.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_soc_gpio_pkg.sv
// Shared constants for the game SoC GPIO block: register word addresses
// and the capture-edge selector encodings.
package game_soc_gpio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

endpackage

// File: rtl/game_soc_gpio_debounce.sv
// Single-bit debouncer: the stable output follows the input only after the
// input has disagreed with it for CYCLES consecutive clocks.
// Only compiled when GAME_SOC_GPIO_DEBOUNCE_EN is defined.
`ifdef GAME_SOC_GPIO_DEBOUNCE_EN
module game_soc_gpio_debounce #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic stable_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        stable_q, stable_d;

  // Count consecutive disagreeing samples; any agreement restarts the count.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (in_i == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == 16'(CYCLES - 1)) begin
      stable_d = in_i;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter and stable value registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule
`endif

// File: rtl/game_soc_gpio_pio.sv
// Avalon-MM GPIO slave for the game SoC: per-bit direction, atomic
// set/clear writes, synchronised edge-captured inputs, level IRQ.
// Optional input debouncing under GAME_SOC_GPIO_DEBOUNCE_EN.
module game_soc_gpio_pio
  import game_soc_gpio_pkg::*;
#(
  parameter int          WIDTH           = 14,
  parameter int          EDGE_TYPE       = 0,
  parameter logic [31:0] DATA_RESET      = 32'h0,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_oe,
  output logic             irq
);

  localparam logic [WIDTH-1:0] DRST = DATA_RESET[WIDTH-1:0];

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0] pin_val;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd_w;
  logic             wr_en;
  logic             wd_unused;

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign wd_unused = ^writedata;

`ifdef GAME_SOC_GPIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    game_soc_gpio_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_i     (sync2_q[i]),
      .stable_o (pin_val[i])
    );
  end
`else
  logic [15:0] db_cfg_unused;
  assign db_cfg_unused = 16'(DEBOUNCE_CYCLES);
  assign pin_val       = sync2_q;
`endif

  // Edge detector against the previous sample of the (cleaned) input.
  always_comb begin
    case (EDGE_TYPE)
      int'(EDGE_FALL): edge_raw = ~pin_val & prev_q;
      int'(EDGE_ANY):  edge_raw = pin_val ^ prev_q;
      default:         edge_raw = pin_val & ~prev_q;
    endcase
  end

  // Register write decode and next-state; a fresh edge beats a same-cycle clear.
  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    clr    = '0;
    if (wr_en) begin
      case (address)
        ADDR_DATA:   data_d = wd;
        ADDR_DIR:    dir_d  = wd;
        ADDR_MASK:   mask_d = wd;
        ADDR_EDGE:   clr    = wd;
        ADDR_OUTSET: data_d = data_q | wd;
        ADDR_OUTCLR: data_d = data_q & ~wd;
        default:     ;
      endcase
    end
    cap_d = (cap_q & ~clr) | (edge_raw & ~dir_q);
    irq_d = |(cap_q & mask_q);
  end

  // Zero-wait-state read mux; DATA mixes driven bits with sampled pins.
  always_comb begin
    rd_w = '0;
    case (address)
      ADDR_DATA: rd_w = (dir_q & data_q) | (~dir_q & pin_val);
      ADDR_DIR:  rd_w = dir_q;
      ADDR_MASK: rd_w = mask_q;
      ADDR_EDGE: rd_w = cap_q;
      default:   rd_w = '0;
    endcase
    readdata            = '0;
    readdata[WIDTH-1:0] = rd_w;
  end

  // Software-visible registers and the input synchroniser chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= DRST;
      dir_q   <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
      irq_q   <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      data_q  <= data_d;
      dir_q   <= dir_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      irq_q   <= irq_d;
      sync1_q <= pin_in;
      sync2_q <= sync1_q;
      prev_q  <= pin_val;
    end
  end

  assign out_port = data_q;
  assign out_oe   = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_game_soc_gpio_pio.sv
// Self-checking bench for game_soc_gpio_pio (WIDTH=14, rising capture).
module tb_game_soc_gpio_pio;
  localparam int W  = 14;
  localparam int ET = 0;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect, write_n;
  logic [31:0]   writedata, readdata;
  logic [W-1:0]  pin_in, out_port, out_oe;
  logic          irq;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: registers as software sees them plus pin history,
  // h0 = pin driven for the coming edge, h1 = one edge older, etc.
  logic [W-1:0] m_data, m_dir, m_mask, m_cap;
  logic         m_irq;
  logic [W-1:0] h0, h1, h2, h3;

  game_soc_gpio_pio #(.WIDTH(W), .EDGE_TYPE(ET), .DATA_RESET(32'h0), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .pin_in(pin_in), .out_port(out_port), .out_oe(out_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] edges(input logic [W-1:0] nw, input logic [W-1:0] od);
    if (ET == 1) return ~nw & od;
    if (ET == 2) return nw ^ od;
    return nw & ~od;
  endfunction

  // What software should read at address a right now.
  function automatic logic [31:0] mread(input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0: r[W-1:0] = (m_dir & m_data) | (~m_dir & h1);
      3'd1: r[W-1:0] = m_dir;
      3'd2: r[W-1:0] = m_mask;
      3'd3: r[W-1:0] = m_cap;
      default: r = '0;
    endcase
    return r;
  endfunction

  // One bus cycle: drive, advance the reference across the edge, land at edge+1.
  task automatic step(input bit wr, input logic [2:0] a, input logic [31:0] wdat, input logic [W-1:0] pin);
    logic [W-1:0] nd, ndir, nmask, clr, wv;
    chipselect = wr; write_n = !wr; address = a; writedata = wdat; pin_in = pin;
    wv = wdat[W-1:0];
    h3 = h2; h2 = h1; h1 = h0; h0 = pin;
    nd = m_data; ndir = m_dir; nmask = m_mask; clr = '0;
    if (wr) begin
      case (a)
        3'd0: nd = wv;
        3'd1: ndir = wv;
        3'd2: nmask = wv;
        3'd3: clr = wv;
        3'd4: nd = m_data | wv;
        3'd5: nd = m_data & ~wv;
        default: ;
      endcase
    end
    m_irq  = |(m_cap & m_mask);
    m_cap  = (m_cap & ~clr) | (edges(h2, h3) & ~m_dir);
    m_data = nd; m_dir = ndir; m_mask = nmask;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; chipselect = 0; write_n = 1; address = 0; writedata = 0;
    pin_in = W'($urandom);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_port !== W'(0)) begin n_bad++; $display("FAIL reset_out_port got %h want 0", out_port); end
    n_cmp++; if (out_oe !== W'(0)) begin n_bad++; $display("FAIL reset_out_oe got %h want 0", out_oe); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b want 0", irq); end
    for (int a = 0; a < 8; a++) begin
      address = 3'(a); #1;
      n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL reset_read addr %0d got %h want 0", a, readdata); end
    end
    pin_in = '0;
    m_data = '0; m_dir = '0; m_mask = '0; m_cap = '0; m_irq = 0;
    h0 = '0; h1 = '0; h2 = '0; h3 = '0;
    reset_n = 1'b1;
  endtask

  task automatic test_outputs();
    step(1, 3'd0, 32'hFFFF_1234, '0);
    n_cmp++; if (out_port !== 14'h1234) begin n_bad++; $display("FAIL data_write got %h want 1234", out_port); end
    step(1, 3'd4, 32'h0000_000F, '0);
    n_cmp++; if (out_port !== 14'h123F) begin n_bad++; $display("FAIL outset got %h want 123f", out_port); end
    address = 3'd4; #1;
    n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL outset_read got %h want 0", readdata); end
    step(1, 3'd5, 32'h0000_0230, '0);
    n_cmp++; if (out_port !== 14'h100F) begin n_bad++; $display("FAIL outclr got %h want 100f", out_port); end
    address = 3'd5; #1;
    n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL outclr_read got %h want 0", readdata); end
  endtask

  task automatic test_dir_readback();
    step(1, 3'd1, 32'h00FF, '0);
    n_cmp++; if (out_oe !== 14'h00FF) begin n_bad++; $display("FAIL dir_write got %h want 00ff", out_oe); end
    n_cmp++; if (out_port !== 14'h100F) begin n_bad++; $display("FAIL dir_keeps_data got %h want 100f", out_port); end
    step(1, 3'd0, 32'h00AA, 14'h3F00);
    step(0, 3'd0, 0, 14'h3F00);
    step(0, 3'd0, 0, 14'h3F00);
    address = 3'd0; #1;
    n_cmp++; if (readdata !== 32'h3FAA) begin n_bad++; $display("FAIL dir_readback got %h want 3faa", readdata); end
  endtask

  task automatic test_rise_capture();
    step(1, 3'd1, 32'h0, '0);
    repeat (3) step(0, 3'd0, 0, '0);
    step(1, 3'd3, 32'h3FFF, '0);
    step(1, 3'd2, 32'h0001, '0);
    step(0, 3'd3, 0, 14'h0001);                      // edge k
    step(0, 3'd3, 0, 14'h0001);                      // k+1
    address = 3'd3; #1;
    n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL cap_early got %h want 0", readdata); end
    step(0, 3'd3, 0, 14'h0001);                      // k+2
    n_cmp++; if (readdata !== 32'h1) begin n_bad++; $display("FAIL cap_k2 got %h want 1", readdata); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_k2 got %b want 0", irq); end
    step(0, 3'd3, 0, 14'h0001);                      // k+3
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_k3 got %b want 1", irq); end
    repeat (5) step(0, 3'd3, 0, '0);
    n_cmp++; if (readdata !== 32'h1) begin n_bad++; $display("FAIL fall_no_cap got %h want 1", readdata); end
    step(1, 3'd3, 32'h1, '0);
    address = 3'd3; #1;
    n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL cap_clear got %h want 0", readdata); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_hold_clear got %b want 1", irq); end
    step(0, 3'd3, 0, '0);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_drop got %b want 0", irq); end
  endtask

  task automatic test_simul_clear();
    step(1, 3'd2, 32'h0008, '0);
    step(0, 3'd0, 0, 14'h0008);
    repeat (3) step(0, 3'd0, 0, 14'h0008);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_bit3 got %b want 1", irq); end
    repeat (4) step(0, 3'd0, 0, '0);
    step(0, 3'd0, 0, 14'h0008);                      // rise r
    step(0, 3'd0, 0, 14'h0008);                      // r+1
    step(1, 3'd3, 32'h0008, 14'h0008);               // r+2: clear meets new edge
    address = 3'd3; #1;
    n_cmp++; if (readdata !== 32'h8) begin n_bad++; $display("FAIL set_beats_clear got %h want 8", readdata); end
    step(0, 3'd3, 0, 14'h0008);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_after_race got %b want 1", irq); end
    step(1, 3'd1, 32'h0020, 14'h0008);
    for (int i = 0; i < 8; i++) step(0, 3'd3, 0, (i % 2) ? 14'h0028 : 14'h0008);
    repeat (3) step(0, 3'd3, 0, 14'h0008);
    n_cmp++; if (readdata !== 32'h8) begin n_bad++; $display("FAIL output_bit_no_cap got %h want 8", readdata); end
  endtask

  task automatic test_random();
    logic [W-1:0] pin;
    logic [2:0]   ra;
    pin = h0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) pin = pin ^ W'($urandom);
      else if ($urandom_range(2) == 0) pin = pin ^ (W'(1) << $urandom_range(W-1));
      step($urandom_range(2) == 0, 3'($urandom_range(7)), $urandom, pin);
      n_cmp++;
      if ({out_port, out_oe, irq} !== {m_data, m_dir, m_irq}) begin
        n_bad++;
        $display("FAIL rand_outputs step %0d got %h/%h/%b want %h/%h/%b", i, out_port, out_oe, irq, m_data, m_dir, m_irq);
      end
      ra = 3'($urandom_range(7));
      address = ra; #1;
      n_cmp++;
      if (readdata !== mread(ra)) begin
        n_bad++;
        $display("FAIL rand_read step %0d addr %0d got %h want %h", i, ra, readdata, mread(ra));
      end
    end
  endtask

  task automatic test_debounce();
    logic seen;
    seen = 0;
    repeat (10) step(0, 3'd0, 0, 14'h0004);
    repeat (30) begin
      step(0, 3'd3, 0, '0);
      if (readdata[2] !== 1'b0) seen = 1;
      address = 3'd0; #1;
      if (readdata[2] !== 1'b0) seen = 1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL db_short_pulse got seen=%b want 0", seen); end
    for (int j = 0; j < 20; j++) begin
      step(0, 3'd3, 0, 14'h0004);                    // j=0 is edge k
      if (j == 17) begin
        n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL db_cap_early got %h want 0", readdata); end
      end
      if (j == 18) begin
        n_cmp++; if (readdata !== 32'h4) begin n_bad++; $display("FAIL db_cap got %h want 4", readdata); end
      end
    end
    repeat (20) step(0, 3'd0, 0, '0);
  endtask

  initial begin
    test_reset();
    test_outputs();
`ifdef GAME_SOC_GPIO_DEBOUNCE_EN
    test_debounce();
`else
    test_dir_readback();
    test_rise_capture();
    test_simul_clear();
    test_random();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
